sram_pipelined_2p: RTL and testbench
====================================

Name: sram_pipelined_2p

Overview:
- Parametrised simple-dual-port SRAM: one read port, one write port, per-word write mask, configurable read latency.
- Read valid strobe travels with the read data through the read pipeline.
- Hardware clear FSM zeroes the array one row per cycle after reset.
- Serves as the backing store for the cache data/tag arrays; replaces the single-mode array.

Parameters:
- WIDTH, 512, row width in bits; must be a multiple of WORDSIZE.
- LOG_DEPTH, 9, log2 of row count; DEPTH = 2**LOG_DEPTH.
- WORDSIZE, 64, write-mask granularity in bits; NW = WIDTH/WORDSIZE.
- DELAY, 1, extra read pipeline stages after the array register; range 0..8.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- init_done  out  1  1 once the clear sweep has completed.
- rd_en  in  1  read request.
- rd_addr  in  LOG_DEPTH  read row.
- rd_valid  out  1  rd_data carries a returned read this cycle.
- rd_data  out  WIDTH  read data.
- wr_mask  in  NW  per-word write enable; any bit set = write.
- wr_addr  in  LOG_DEPTH  write row.
- wr_data  in  WIDTH  write data.

Behaviour:
- Reset values: init_done=0, rd_valid=0, rd_data=0. All pipeline valid bits cleared. Clear counter=0. FSM=CLEAR.
- FSM states:
  - CLEAR: each cycle writes all-zero to row clr_cnt, then clr_cnt++.
  - At clr_cnt==DEPTH-1 the row is written and the FSM moves to READY next cycle.
  - READY: normal operation; init_done=1.
- CLEAR takes exactly DEPTH cycles after reset deasserts.
- During CLEAR, rd_en and wr_mask are ignored:
  - no array write from the ports;
  - no rd_valid is generated, including for requests issued in the last CLEAR cycle.
- Reset asserted mid-clear or in READY:
  - restarts CLEAR at row 0;
  - flushes in-flight reads, so no rd_valid for them.
- Read timing: rd_en=1 in READY at cycle t gives rd_valid=1 and rd_data=mem[rd_addr] at cycle t+1+DELAY.
- Read pipeline:
  - Fully pipelined: one read accepted per cycle, back-to-back.
  - Valid bit shifts alongside the data in every stage.
- rd_data holds its last returned value while rd_valid=0.
- Write: for each i where wr_mask[i]=1, mem[wr_addr][i*WORDSIZE +: WORDSIZE] <= the matching wr_data slice. Unmasked words are unchanged.
- Same-cycle read and write to the same address: read-first. The read returns pre-write contents (overridden by the optional feature).
- Write in cycle t is visible to a read issued at cycle t+1 or later.
- Address arithmetic: clr_cnt is LOG_DEPTH+1 bits so the terminal compare does not wrap.
- Port addresses are LOG_DEPTH bits; no out-of-range case.
- Elaboration checks (fatal):
  - WIDTH % WORDSIZE != 0;
  - DELAY > 8.
- Message printed: size in KB, geometry, DELAY.

Optional Feature:
- Macro: SRAM_RW_BYPASS_EN.
- Defined: same-cycle same-address read and write returns write-first data. Masked words come from wr_data; unmasked words come from the old array contents. The merge happens at the array-register stage, then flows through the DELAY stages unchanged.
- Not defined: read-first as described above; no bypass mux is synthesised.

Test Plan:
- Clear sequence: reset 1 cycle with LOG_DEPTH=4. Required:
  - init_done=0 for 16 cycles, then 1;
  - reads of rows 0..15 return 0;
  - rd_en pulsed during CLEAR gives no rd_valid.
- Latency: DELAY=0, 1 and 3. Write row 5 = 0xA5 pattern, then rd_en row 5 at cycle t. Required: rd_valid exactly at t+1, t+2 and t+4 respectively, data correct; rd_data holds afterwards.
- Masked write: row 7 = all-ones, then wr_mask=8'b0000_0101 with wr_data=0. Required: read row 7 shows words 0 and 2 zero, others all-ones.
- Back-to-back: rd_en for rows 0..7 on consecutive cycles. Required: 8 consecutive rd_valid cycles, in order, correct data.
- Same-address collision: row 3 = X, then same cycle wr row 3 = Y (full mask) and rd row 3. Required: returns X without the macro, Y with SRAM_RW_BYPASS_EN; a following read returns Y in both builds.
- Reset mid-flight: DELAY=2, rd_en accepted, then reset the next cycle. Required: no rd_valid; init_done=0; clear restarts at row 0.

Source files
------------

// File: rtl/sram_pipelined_2p.sv
// Simple-dual-port SRAM with per-word write mask, DELAY-stage read pipeline and post-reset clear.
// Define SRAM_RW_BYPASS_EN for write-first behaviour on same-cycle same-address read/write.
module sram_pipelined_2p #(
  parameter int unsigned WIDTH     = 512,
  parameter int unsigned LOG_DEPTH = 9,
  parameter int unsigned WORDSIZE  = 64,
  parameter int unsigned DELAY     = 1,
  localparam int unsigned NW       = WIDTH / WORDSIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 init_done_o,
  input  logic                 rd_en_i,
  input  logic [LOG_DEPTH-1:0] rd_addr_i,
  output logic                 rd_valid_o,
  output logic [WIDTH-1:0]     rd_data_o,
  input  logic [NW-1:0]        wr_mask_i,
  input  logic [LOG_DEPTH-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]     wr_data_i
);

  localparam int unsigned DEPTH = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] ClrLast = (LOG_DEPTH + 1)'(DEPTH - 1);

  if (WIDTH % WORDSIZE != 0) begin : g_bad_width
    $fatal(1, "sram_pipelined_2p: WIDTH %0d not a multiple of WORDSIZE %0d", WIDTH, WORDSIZE);
  end
  if (DELAY > 8) begin : g_bad_delay
    $fatal(1, "sram_pipelined_2p: DELAY %0d out of range 0..8", DELAY);
  end
  if (1) begin : g_info
    $info("sram_pipelined_2p: %0d KB, %0d rows x %0d bits, %0d-bit words, DELAY=%0d",
          (WIDTH * DEPTH) / 8192, DEPTH, WIDTH, WORDSIZE, DELAY);
  end

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e               state_q, state_d;
  logic [LOG_DEPTH:0]   clr_cnt_q, clr_cnt_d;
  logic                 ready;
  logic                 rd_fire;
  logic [WIDTH-1:0]     rd_word;
  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [DELAY:0]       vld_q;
  logic [WIDTH-1:0]     dat_q [DELAY+1];

  assign ready   = (state_q == StReady);
  assign rd_fire = ready && rd_en_i;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == StClear) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == ClrLast) state_d = StReady;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Port writes are locked out until the sweep finishes.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem_q[clr_cnt_q[LOG_DEPTH-1:0]] <= '0;
    end else begin
      for (int unsigned i = 0; i < NW; i++) begin
        if (wr_mask_i[i]) begin
          mem_q[wr_addr_i][i*WORDSIZE +: WORDSIZE] <= wr_data_i[i*WORDSIZE +: WORDSIZE];
        end
      end
    end
  end

  always_comb begin
    rd_word = mem_q[rd_addr_i];
`ifdef SRAM_RW_BYPASS_EN
    if (ready && (wr_addr_i == rd_addr_i)) begin
      for (int unsigned i = 0; i < NW; i++) begin
        if (wr_mask_i[i]) rd_word[i*WORDSIZE +: WORDSIZE] = wr_data_i[i*WORDSIZE +: WORDSIZE];
      end
    end
`endif
  end

  // Data stages only load on a valid so the output holds between returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int unsigned k = 0; k <= DELAY; k++) dat_q[k] <= '0;
    end else begin
      vld_q[0] <= rd_fire;
      if (rd_fire) dat_q[0] <= rd_word;
      for (int unsigned k = 1; k <= DELAY; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) dat_q[k] <= dat_q[k-1];
      end
    end
  end

  assign init_done_o = ready;
  assign rd_valid_o  = vld_q[DELAY];
  assign rd_data_o   = dat_q[DELAY];

endmodule

// File: tb/tb_sram_pipelined_2p.sv
// Bench for sram_pipelined_2p: four instances (DELAY 0..3) share stimulus and are checked
// against an array model of the memory with per-instance expected return latency.
module tb_sram_pipelined_2p;

  localparam int W   = 512;
  localparam int WS  = 64;
  localparam int NW  = W / WS;
  localparam int LD  = 4;
  localparam int DEP = 1 << LD;
  localparam int ND  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_en;
  logic [LD-1:0] rd_addr;
  logic [NW-1:0] wr_mask;
  logic [LD-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [ND-1:0] init_done;
  logic [ND-1:0] rd_valid;
  logic [W-1:0]  rd_data [ND];

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [W-1:0]  ref_mem [DEP];
  logic [W-1:0]  last [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    sram_pipelined_2p #(
      .WIDTH(W), .LOG_DEPTH(LD), .WORDSIZE(WS), .DELAY(g)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .init_done_o(init_done[g]),
      .rd_en_i    (rd_en),
      .rd_addr_i  (rd_addr),
      .rd_valid_o (rd_valid[g]),
      .rd_data_o  (rd_data[g]),
      .wr_mask_i  (wr_mask),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data)
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [NW-1:0] m,
                                         input logic [W-1:0] d);
    logic [W-1:0] r = old;
    for (int i = 0; i < NW; i++) if (m[i]) r[i*WS +: WS] = d[i*WS +: WS];
    return r;
  endfunction

  task automatic do_write(input logic [LD-1:0] a, input logic [NW-1:0] m, input logic [W-1:0] d);
    wr_addr = a;
    wr_mask = m;
    wr_data = d;
    tick();
    wr_mask = '0;
    ref_mem[a] = merge(ref_mem[a], m, d);
  endtask

  // Issue n reads of consecutive rows from base; instance g must return read j at step j+g.
  task automatic test_back_to_back(input string name, input logic [LD-1:0] base, input int n);
    for (int k = 0; k <= n + ND; k++) begin
      rd_en   = (k < n);
      rd_addr = LD'(base + k);
      tick();
      for (int g = 0; g < ND; g++) begin
        int   j  = k - g;
        logic ev = (j >= 0) && (j < n);
        if (ev) last[g] = ref_mem[LD'(base + j)];
        n_tests++;
        if (rd_valid[g] !== ev) begin
          n_fail++;
          $display("FAIL %s valid dut%0d step%0d got %b want %b", name, g, k, rd_valid[g], ev);
        end
        n_tests++;
        if (rd_data[g] !== last[g]) begin
          n_fail++;
          $display("FAIL %s data dut%0d step%0d got %h want %h", name, g, k, rd_data[g], last[g]);
        end
      end
    end
    rd_en = 1'b0;
  endtask

  // Runs a full clear; random port traffic during the sweep must have no effect.
  task automatic run_clear(input string name);
    for (int c = 0; c <= DEP; c++) begin
      for (int g = 0; g < ND; g++) begin
        n_tests++;
        if (init_done[g] !== (c == DEP)) begin
          n_fail++;
          $display("FAIL %s init_done dut%0d cyc%0d got %b want %b", name, g, c, init_done[g],
                   c == DEP);
        end
        n_tests++;
        if (rd_valid[g] !== 1'b0) begin
          n_fail++;
          $display("FAIL %s rd_valid_in_clear dut%0d cyc%0d got %b want 0", name, g, c,
                   rd_valid[g]);
        end
      end
      if (c < DEP) begin
        rd_en   = $urandom_range(0, 1);
        rd_addr = LD'($urandom);
        wr_mask = NW'($urandom);
        wr_addr = LD'($urandom);
        wr_data = rand_row();
        tick();
      end
    end
    rd_en   = 1'b0;
    wr_mask = '0;
    for (int k = 0; k < ND; k++) begin
      tick();
      for (int g = 0; g < ND; g++) begin
        n_tests++;
        if (rd_valid[g] !== 1'b0) begin
          n_fail++;
          $display("FAIL %s late_valid dut%0d got %b want 0", name, g, rd_valid[g]);
        end
      end
    end
    for (int r = 0; r < DEP; r++) ref_mem[r] = '0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    rd_en   = 1'b0;
    rd_addr = '0;
    wr_mask = '0;
    wr_addr = '0;
    wr_data = '0;
    tick();
    for (int g = 0; g < ND; g++) begin
      n_tests++;
      if (rd_data[g] !== '0 || rd_valid[g] !== 1'b0 || init_done[g] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d got valid=%b done=%b data=%h want 0/0/0", g,
                 rd_valid[g], init_done[g], rd_data[g]);
      end
      last[g] = '0;
    end
    reset = 1'b0;
    run_clear("clear");
    test_back_to_back("clear_rows", '0, DEP);
  endtask

  task automatic test_latency();
    do_write(LD'(5), '1, {(W/8){8'hA5}});
    test_back_to_back("latency", LD'(5), 1);
  endtask

  task automatic test_masked();
    do_write(LD'(7), '1, '1);
    do_write(LD'(7), NW'(8'b0000_0101), '0);
    test_back_to_back("masked", LD'(7), 1);
  endtask

  task automatic test_b2b_rows();
    for (int r = 0; r < 8; r++) do_write(LD'(r), '1, rand_row());
    test_back_to_back("back_to_back", '0, 8);
  endtask

  task automatic test_collision();
    logic [W-1:0] x = rand_row();
    logic [W-1:0] y = rand_row();
    logic [W-1:0] e [2];
    do_write(LD'(3), '1, x);
`ifdef SRAM_RW_BYPASS_EN
    e[0] = y;
`else
    e[0] = x;
`endif
    e[1] = y;
    for (int k = 0; k <= 1 + ND; k++) begin
      rd_en   = (k < 2);
      rd_addr = LD'(3);
      wr_mask = (k == 0) ? '1 : '0;
      wr_addr = LD'(3);
      wr_data = y;
      tick();
      if (k == 0) ref_mem[3] = y;
      for (int g = 0; g < ND; g++) begin
        int   j  = k - g;
        logic ev = (j >= 0) && (j < 2);
        if (ev) last[g] = e[j];
        n_tests++;
        if (rd_valid[g] !== ev || rd_data[g] !== last[g]) begin
          n_fail++;
          $display("FAIL collision dut%0d step%0d got v=%b %h want v=%b %h", g, k, rd_valid[g],
                   rd_data[g], ev, last[g]);
        end
      end
    end
    rd_en   = 1'b0;
    wr_mask = '0;
  endtask

  task automatic test_random();
    logic [W-1:0] ex_d [$];
    int           ex_c [$];
    int           ptr  [ND];
    localparam int N = 200;
    for (int g = 0; g < ND; g++) ptr[g] = 0;
    for (int k = 0; k <= N + ND; k++) begin
      rd_en   = (k < N) && ($urandom_range(0, 3) != 0);
      rd_addr = LD'($urandom);
      wr_mask = ((k < N) && ($urandom_range(0, 2) != 0)) ? NW'($urandom) : '0;
      wr_addr = ($urandom_range(0, 3) == 0) ? rd_addr : LD'($urandom);
      wr_data = rand_row();
      if (rd_en) begin
`ifdef SRAM_RW_BYPASS_EN
        ex_d.push_back((wr_addr == rd_addr) ? merge(ref_mem[rd_addr], wr_mask, wr_data)
                                            : ref_mem[rd_addr]);
`else
        ex_d.push_back(ref_mem[rd_addr]);
`endif
        ex_c.push_back(k);
      end
      ref_mem[wr_addr] = merge(ref_mem[wr_addr], wr_mask, wr_data);
      tick();
      for (int g = 0; g < ND; g++) begin
        logic ev = (ptr[g] < ex_c.size()) && (ex_c[ptr[g]] + g == k);
        if (ev) begin
          last[g] = ex_d[ptr[g]];
          ptr[g]++;
        end
        n_tests++;
        if (rd_valid[g] !== ev || rd_data[g] !== last[g]) begin
          n_fail++;
          $display("FAIL random dut%0d step%0d got v=%b %h want v=%b %h", g, k, rd_valid[g],
                   rd_data[g], ev, last[g]);
        end
      end
    end
    rd_en   = 1'b0;
    wr_mask = '0;
  endtask

  task automatic test_reset_midflight();
    rd_en   = 1'b1;
    rd_addr = LD'($urandom);
    tick();
    rd_en = 1'b0;
    n_tests++;
    if (rd_valid[0] !== 1'b1 || rd_data[0] !== ref_mem[rd_addr]) begin
      n_fail++;
      $display("FAIL midflight_pre dut0 got v=%b %h want v=1 %h", rd_valid[0], rd_data[0],
               ref_mem[rd_addr]);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int g = 0; g < ND; g++) begin
      last[g] = '0;
      n_tests++;
      if (rd_valid[g] !== 1'b0 || init_done[g] !== 1'b0 || rd_data[g] !== '0) begin
        n_fail++;
        $display("FAIL midflight_reset dut%0d got v=%b done=%b data=%h want 0/0/0", g,
                 rd_valid[g], init_done[g], rd_data[g]);
      end
    end
    // Partial sweep, then reset again: full DEPTH cycles must follow the second reset.
    for (int c = 0; c < 5; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_clear("midclear");
    test_back_to_back("midclear_rows", '0, DEP);
  endtask

  initial begin
    for (int r = 0; r < DEP; r++) ref_mem[r] = '0;
    test_reset();
    test_latency();
    test_masked();
    test_b2b_rows();
    test_collision();
    test_back_to_back("collision_after", LD'(3), 1);
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
